// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side controller.
// Build option FIFO_RD_PARITY_EN adds per-entry even parity on the output stream.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer between the FIFO pop path and the valid/ready stream.
// With FIFO_RD_PARITY_EN defined each entry also stores the parity of its data.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output logic             head_parity,
  output logic [1:0]       occ
);

`ifdef FIFO_RD_PARITY_EN
  localparam int EW = WIDTH + 1;
  logic [EW-1:0] push_entry;
  assign push_entry = {^push_data, push_data};
`else
  localparam int EW = WIDTH;
  logic [EW-1:0] push_entry;
  assign push_entry = push_data;
`endif

  logic [EW-1:0] entry0;
  logic [EW-1:0] entry1;
  logic [1:0]    occ_q;
  logic          pop_ok;
  logic          push_ok;

  // A push into a full buffer is only accepted when the head leaves on the same edge.
  assign pop_ok  = pop && (occ_q != OCC_EMPTY);
  assign push_ok = push && ((occ_q != OCC_FULL) || pop_ok);

  // NOTE: the entries are reset because OUT_DATA must read zero out of reset;
  // a plain storage array with no such visibility would be left unreset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      occ_q  <= OCC_EMPTY;
      entry0 <= '0;
      entry1 <= '0;
    end else if (clear) begin
      occ_q <= OCC_EMPTY;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (push_ok) begin
            entry0 <= push_entry;
            occ_q  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push_ok && pop_ok) begin
            entry0 <= push_entry;
          end else if (push_ok) begin
            entry1 <= push_entry;
            occ_q  <= OCC_FULL;
          end else if (pop_ok) begin
            occ_q <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop_ok) begin
            entry0 <= entry1;
            if (push_ok) entry1 <= push_entry;
            else         occ_q  <= OCC_ONE;
          end
        end
        default: occ_q <= OCC_EMPTY;
      endcase
    end
  end

  assign head_data = entry0[WIDTH-1:0];
`ifdef FIFO_RD_PARITY_EN
  assign head_parity = entry0[WIDTH];
`else
  assign head_parity = 1'b0;
`endif
  assign occ = occ_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the async FIFO: pops words into a 2-entry buffer, streams them
// out, supports flush-until-empty and counts deliveries. Option: FIFO_RD_PARITY_EN.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     R_DATA,
  input  logic                 EMPTY,
  output logic                 R_INC,
  input  logic                 ENABLE,
  input  logic                 FLUSH,
  output logic [WIDTH-1:0]     OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OUT_PARITY,
  output logic                 FLUSH_DONE,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] RD_COUNT
);

  state_t     state;
  state_t     state_nxt;
  logic       r_inc;
  logic [1:0] occ;
  logic       flush_entry;
  logic       push;
  logic       handshake;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // R_INC depends only on state, occupancy and EMPTY, never on OUT_READY.
  // NOTE: every output of this always_comb gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    r_inc     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (FLUSH)       state_nxt = ST_FLUSH;
        else if (ENABLE) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        r_inc = !EMPTY && (occ < OCC_FULL);
        if (FLUSH)        state_nxt = ST_FLUSH;
        else if (!ENABLE) state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        r_inc = !EMPTY;
        if (EMPTY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign R_INC       = r_inc;
  assign flush_entry = (state_nxt == ST_FLUSH) && (state != ST_FLUSH);
  assign push        = r_inc && (state == ST_RUN);
  assign OUT_VALID   = (occ != OCC_EMPTY);
  assign handshake   = OUT_VALID && OUT_READY;
  assign BUSY        = (state != ST_IDLE) || OUT_VALID;

  fifo_rd_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .CLK        (CLK),
    .RST        (RST),
    .push       (push),
    .push_data  (R_DATA),
    .pop        (handshake),
    .clear      (flush_entry),
    .head_data  (OUT_DATA),
    .head_parity(OUT_PARITY),
    .occ        (occ)
  );

  // The edge that samples EMPTY in FLUSH is the one that returns to IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) FLUSH_DONE <= 1'b0;
    else      FLUSH_DONE <= (state == ST_FLUSH) && EMPTY;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           RD_COUNT <= '0;
    else if (handshake) RD_COUNT <= RD_COUNT + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl with a queue-based FIFO model and
// a narrow delivered-word counter so the wrap is reachable.
module tb_fifo_rd_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] R_DATA;
  logic             EMPTY;
  logic             R_INC;
  logic             ENABLE;
  logic             FLUSH;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OUT_PARITY;
  logic             FLUSH_DONE;
  logic             BUSY;
  logic [CW-1:0]    RD_COUNT;

  fifo_rd_ctrl #(
    .WIDTH    (WIDTH),
    .CNT_WIDTH(CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .R_DATA    (R_DATA),
    .EMPTY     (EMPTY),
    .R_INC     (R_INC),
    .ENABLE    (ENABLE),
    .FLUSH     (FLUSH),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_PARITY(OUT_PARITY),
    .FLUSH_DONE(FLUSH_DONE),
    .BUSY      (BUSY),
    .RD_COUNT  (RD_COUNT)
  );

  always #5 CLK = ~CLK;

  logic [WIDTH-1:0] fifo_q[$];
  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [WIDTH-1:0] d);
`ifdef FIFO_RD_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic refresh();
    EMPTY  = (fifo_q.size() == 0);
    R_DATA = EMPTY ? '0 : fifo_q[0];
  endtask

  task automatic load(input logic [WIDTH-1:0] d);
    fifo_q.push_back(d);
    refresh();
  endtask

  // Advance one rising edge; the FIFO model pops just after the edge if R_INC was high.
  task automatic cyc();
    logic pre;
    #1;
    pre = R_INC;
    check("no_pop_when_empty", 32'(R_INC & EMPTY), 32'd0);
    @(posedge CLK);
    #1;
    if (pre && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    refresh();
    @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(OUT_VALID),  32'd0);
    check({tag, "_data"},  32'(OUT_DATA),   32'd0);
    check({tag, "_par"},   32'(OUT_PARITY), 32'd0);
    check({tag, "_done"},  32'(FLUSH_DONE), 32'd0);
    check({tag, "_cnt"},   32'(RD_COUNT),   32'd0);
    check({tag, "_busy"},  32'(BUSY),       32'd0);
    check({tag, "_rinc"},  32'(R_INC),      32'd0);
  endtask

  logic [WIDTH-1:0] t1_words [3] = '{8'h11, 8'h22, 8'h33};
  logic [WIDTH-1:0] t2_words [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

  initial begin
    int done_hits;
    int done_at;

    ENABLE    = 1'b0;
    FLUSH     = 1'b0;
    OUT_READY = 1'b0;
    refresh();

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b1;

    // Basic stream: three words at full rate
    foreach (t1_words[i]) load(t1_words[i]);
    ENABLE    = 1'b1;
    OUT_READY = 1'b1;
    pops      = 0;
    cyc();
    check("t1_rinc_first", 32'(R_INC), 32'd1);
    check("t1_valid_first", 32'(OUT_VALID), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t1_valid", 32'(OUT_VALID), 32'd1);
      check("t1_data", 32'(OUT_DATA), 32'(t1_words[i]));
      check("t1_cnt", 32'(RD_COUNT), 32'(i));
      check("t1_rinc", 32'(R_INC), (i < 2) ? 32'd1 : 32'd0);
    end
    ENABLE = 1'b0;
    cyc();
    check("t1_cnt_end", 32'(RD_COUNT), 32'd3);
    check("t1_busy_end", 32'(BUSY), 32'd0);
    check("t1_pops", 32'(pops), 32'd3);

    // Backpressure: buffer saturates at two words
    OUT_READY = 1'b0;
    foreach (t2_words[i]) load(t2_words[i]);
    ENABLE = 1'b1;
    pops   = 0;
    cyc();
    cyc();
    cyc();
    check("t2_rinc_full", 32'(R_INC), 32'd0);
    check("t2_hold_data", 32'(OUT_DATA), 32'hA1);
    check("t2_pops2", 32'(pops), 32'd2);
    cyc();
    check("t2_hold_data2", 32'(OUT_DATA), 32'hA1);
    check("t2_hold_valid", 32'(OUT_VALID), 32'd1);
    check("t2_pops2b", 32'(pops), 32'd2);
    OUT_READY = 1'b1;
    #1;
    check("t2_no_ready_path", 32'(R_INC), 32'd0);
    for (int i = 1; i < 5; i++) begin
      cyc();
      check("t2_data", 32'(OUT_DATA), 32'(t2_words[i]));
      check("t2_cnt", 32'(RD_COUNT), 32'(3 + i));
    end
    cyc();
    check("t2_valid_end", 32'(OUT_VALID), 32'd0);
    check("t2_cnt_end", 32'(RD_COUNT), 32'd8);
    check("t2_pops", 32'(pops), 32'd5);

    // ENABLE dropped with two words buffered
    OUT_READY = 1'b0;
    load(8'hB1);
    load(8'hB2);
    load(8'hB3);
    cyc();
    cyc();
    check("t3_rinc_full", 32'(R_INC), 32'd0);
    check("t3_head", 32'(OUT_DATA), 32'hB1);
    ENABLE    = 1'b0;
    OUT_READY = 1'b1;
    cyc();
    check("t3_data2", 32'(OUT_DATA), 32'hB2);
    check("t3_cnt9", 32'(RD_COUNT), 32'd9);
    check("t3_busy", 32'(BUSY), 32'd1);
    check("t3_rinc_idle", 32'(R_INC), 32'd0);
    cyc();
    check("t3_valid_end", 32'(OUT_VALID), 32'd0);
    check("t3_busy_end", 32'(BUSY), 32'd0);
    check("t3_cnt10", 32'(RD_COUNT), 32'd10);
    check("t3_fifo_left", 32'(fifo_q.size()), 32'd1);

    // Flush with one word buffered and four in the FIFO
    OUT_READY = 1'b0;
    ENABLE    = 1'b1;
    cyc();
    cyc();
    foreach (t2_words[i]) if (i < 4) load(8'hC1 + 8'(i));
    check("t4_pre_valid", 32'(OUT_VALID), 32'd1);
    check("t4_pre_data", 32'(OUT_DATA), 32'hB3);
    FLUSH = 1'b1;
    pops  = 0;
    cyc();
    check("t4_valid_drop", 32'(OUT_VALID), 32'd0);
    check("t4_busy", 32'(BUSY), 32'd1);
    check("t4_done_early", 32'(FLUSH_DONE), 32'd0);
    FLUSH     = 1'b0;
    done_hits = 0;
    done_at   = -1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (FLUSH_DONE) begin
        done_hits++;
        if (done_at < 0) done_at = i;
      end
    end
    check("t4_done_pulses", 32'(done_hits), 32'd1);
    check("t4_done_cycle", 32'(done_at), 32'd4);
    check("t4_pops", 32'(pops), 32'd4);
    check("t4_cnt", 32'(RD_COUNT), 32'd10);
    check("t4_valid_after", 32'(OUT_VALID), 32'd0);
    ENABLE = 1'b0;
    cyc();

    // Asynchronous reset with two words buffered
    load(8'hD1);
    load(8'hD2);
    load(8'hD3);
    load(8'hD4);
    ENABLE = 1'b1;
    cyc();
    cyc();
    cyc();
    check("t6_head", 32'(OUT_DATA), 32'hD1);
    check("t6_rinc_full", 32'(R_INC), 32'd0);
    OUT_READY = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge CLK);
    RST = 1'b1;
    cyc();
    check("t6_rinc_resume", 32'(R_INC), 32'd1);
    cyc();
    check("t6_resume_data", 32'(OUT_DATA), 32'hD3);
    check("t6_resume_cnt", 32'(RD_COUNT), 32'd0);
    cyc();
    check("t6_data4", 32'(OUT_DATA), 32'hD4);
    check("t6_cnt1", 32'(RD_COUNT), 32'd1);
    cyc();
    check("t6_valid_end", 32'(OUT_VALID), 32'd0);
    check("t6_cnt2", 32'(RD_COUNT), 32'd2);
    ENABLE = 1'b0;
    cyc();

    // Counter wrap and parity over 17 words
    RST = 1'b0;
    #1;
    check("t5_cnt_clear", 32'(RD_COUNT), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 17; i++) load(8'(i + 1));
    ENABLE    = 1'b1;
    OUT_READY = 1'b1;
    cyc();
    for (int i = 0; i < 17; i++) begin
      cyc();
      check("t5_valid", 32'(OUT_VALID), 32'd1);
      check("t5_data", 32'(OUT_DATA), 32'(i + 1));
      check("t5_cnt", 32'(RD_COUNT), 32'(i % 16));
      check("t5_par", 32'(OUT_PARITY), 32'(exp_par(8'(i + 1))));
    end
    cyc();
    check("t5_cnt_wrap", 32'(RD_COUNT), 32'd1);
    check("t5_valid_end", 32'(OUT_VALID), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller that drains the asynchronous FIFO in the read clock domain. It watches EMPTY, pulses R_INC, and captures first-word-fall-through R_DATA into a 2-entry output buffer. The buffer drives a valid/ready stream toward the downstream consumer. It also provides enable gating, a flush (discard-until-empty) mode and a delivered-word counter.

## Interface
- WIDTH, 8, data word width (matches FIFO WIDTH)
- CNT_WIDTH, 16, width of delivered-word counter
- CLK  input  1  read-domain clock (connects to FIFO R_CLK)
- RST  input  1  asynchronous, active-low reset; same net as FIFO R_RST
- R_DATA  input  WIDTH  FIFO read data, valid whenever EMPTY=0
- EMPTY  input  1  FIFO empty flag
- R_INC  output  1  pop strobe to FIFO; combinational from state, occupancy and EMPTY only
- ENABLE  input  1  level; 1 = allow popping in RUN
- FLUSH  input  1  level; request discard of all FIFO contents
- OUT_DATA  output  WIDTH  stream data (head of buffer)
- OUT_VALID  output  1  stream valid
- OUT_READY  input  1  stream ready from consumer
- OUT_PARITY  output  1  even parity of OUT_DATA (see Configuration)
- FLUSH_DONE  output  1  one-cycle pulse when flush completes
- BUSY  output  1  1 when state≠IDLE or buffer occupancy≠0
- RD_COUNT  output  CNT_WIDTH  count of OUT_VALID&&OUT_READY handshakes, wraps modulo 2^CNT_WIDTH

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE→FLUSH when FLUSH=1; else IDLE→RUN when ENABLE=1.
- RUN→FLUSH when FLUSH=1; else RUN→IDLE when ENABLE=0.
- FLUSH→IDLE when EMPTY=1 sampled at an edge while in FLUSH; FLUSH_DONE pulses that cycle+1; FLUSH input ignored while in FLUSH.
- FLUSH has priority over ENABLE on the same edge.
- Buffer occupancy occ ∈ {0,1,2}, registered.
- RUN: R_INC = !EMPTY && occ<2. A popped word is written at the tail of the buffer on the same edge.
- IDLE: R_INC=0. Buffered words still drain to the consumer.
- FLUSH: R_INC = !EMPTY. Popped words are discarded. On FLUSH entry, occ→0 and OUT_VALID→0; buffered words are dropped and not counted.
- OUT_VALID = (occ≠0). OUT_DATA = head entry.
- Handshake: OUT_VALID&&OUT_READY at an edge removes the head.
- Simultaneous push and handshake leaves occ unchanged and advances the head.
- Once asserted, OUT_VALID and OUT_DATA hold stable until handshake, except on FLUSH entry or reset.
- RD_COUNT increments by 1 per handshake; 2^CNT_WIDTH−1 → 0.
- R_INC is never asserted while EMPTY=1.

## Timing
- Reset (async assert, sync release to CLK edge): state=IDLE, occ=0, OUT_VALID=0, OUT_DATA=0, OUT_PARITY=0, FLUSH_DONE=0, RD_COUNT=0, BUSY=0. R_INC=0 as a consequence.
- Reset mid-operation: buffered words are lost; no partial handshake is completed.
- Latency: R_INC high at edge k → word on OUT_DATA with OUT_VALID=1 after edge k. That is one cycle from pop to valid, and two cycles from ENABLE rising with the FIFO non-empty.
- Throughput: 1 word/cycle sustained with OUT_READY=1 (steady state occ=1).
- If OUT_READY is held low, occ saturates at 2 and R_INC stops.
- No combinational path exists from OUT_READY to R_INC.
- FLUSH: one FIFO word is discarded per cycle. FLUSH_DONE is registered and is high exactly one cycle.

## Configuration
- FIFO_RD_PARITY_EN defined: OUT_PARITY = XOR of OUT_DATA bits, stored per buffer entry at push time.
- Not defined: OUT_PARITY tied to 0 and the parity storage is removed.

## Structure
- Package fifo_rd_pkg:
  - state encodings IDLE=2'b00, RUN=2'b01, FLUSH=2'b10
  - occupancy constants OCC_EMPTY=0 and OCC_FULL=2
- One sub-module, fifo_rd_skid: 2-entry buffer holding data (+parity), occ, push/pop/clear. The top-level module holds the FSM, the R_INC logic and the counter.

## Test plan
- Reset then ENABLE=1 with the FIFO model preloaded 0x11,0x22,0x33 and OUT_READY=1 → R_INC high 3 consecutive cycles; OUT_DATA 0x11,0x22,0x33 on consecutive cycles; RD_COUNT=3; BUSY falls after the last handshake.
- OUT_READY=0 with 5 words queued → exactly 2 pops, occ=2, R_INC=0, OUT_DATA=first word held stable. Release OUT_READY → remaining 3 delivered in order, RD_COUNT=5.
- ENABLE dropped with occ=2 → no further R_INC; both buffered words still delivered; state IDLE.
- FLUSH=1 with 4 words in FIFO and occ=1 → OUT_VALID=0 next cycle; 4 pops with no handshakes; FLUSH_DONE one-cycle pulse; RD_COUNT unchanged.
- CNT_WIDTH=4, 17 words streamed → RD_COUNT wraps to 1. With FIFO_RD_PARITY_EN defined, word 0x07 shows OUT_PARITY=1 and 0x03 shows 0.
- RST asserted while occ=2 and streaming → all outputs zero asynchronously; after release, ENABLE=1 resumes from the next FIFO word.
